// File: rtl/spi_master.sv
// spi_master: memory-mapped SPI mode-0 master on the SoC data bus.
//
// Register map (16 bytes at SPI_BASE, word select addr[3:2]):
//   0x0 CTRL    RW  [0] enable, [1] irq_en, [15:8] clkdiv
//   0x4 STATUS      [0] busy, [1] tx_full, [2] rx_valid, [3] overrun (write 1 to clear)
//   0x8 TXDATA  WO  [7:0] byte to send, reads as 0
//   0xC RXDATA  RO  [7:0] last received byte, read clears rx_valid
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   spi_r_addr_i/_en_i   bus read address / strobe; spi_data_o is registered (1-cycle latency)
//   spi_w_addr_i/_en_i   bus write address / strobe, spi_data_i write data
//   spi_irq_o            level interrupt = rx_valid & irq_en
//   sclk, mosi, miso     SPI pins, mode 0, MSB first
//   cs_n                 chip select, active low
//
// Build option: define SPI_TX_FIFO_EN for a 4-entry transmit FIFO; otherwise a
// single holding register queues the next byte.
module spi_master #(
  parameter logic [31:0] SPI_BASE  = 32'h8000_0200,
  parameter logic [7:0]  DIV_RESET = 8'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] spi_r_addr_i,
  input  logic [31:0] spi_w_addr_i,
  input  logic [31:0] spi_data_i,
  input  logic        spi_r_enable_i,
  input  logic        spi_w_enable_i,
  output logic [31:0] spi_data_o,
  output logic        spi_irq_o,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        cs_n
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_SHIFT = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_TXDATA = 2'd2;
  localparam logic [1:0] REG_RXDATA = 2'd3;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  half_q, half_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        cs_n_q, cs_n_d;
  logic        enable_q, enable_d;
  logic        irq_en_q, irq_en_d;
  logic [7:0]  clkdiv_q, clkdiv_d;
  logic        rx_valid_q, rx_valid_d;
  logic        overrun_q, overrun_d;
  logic [7:0]  rxdata_q, rxdata_d;
  logic [31:0] data_o_q, data_o_d;

  logic        r_hit, w_hit, w_ctrl, w_status, w_tx, r_rx;
  logic        busy, tx_full, tx_pending, tx_accept, start, abort, done;
  logic [7:0]  tx_byte;
  logic [31:0] rdata;
  logic        unused_bits;

  assign r_hit    = spi_r_enable_i && (spi_r_addr_i[31:4] == SPI_BASE[31:4]);
  assign w_hit    = spi_w_enable_i && (spi_w_addr_i[31:4] == SPI_BASE[31:4]);
  assign w_ctrl   = w_hit && (spi_w_addr_i[3:2] == REG_CTRL);
  assign w_status = w_hit && (spi_w_addr_i[3:2] == REG_STATUS);
  assign w_tx     = w_hit && (spi_w_addr_i[3:2] == REG_TXDATA);
  assign r_rx     = r_hit && (spi_r_addr_i[3:2] == REG_RXDATA);

  assign busy      = (state_q != S_IDLE);
  assign tx_accept = w_tx && enable_q && !tx_full;
  assign start     = (state_q == S_IDLE) && tx_pending && enable_q;
  // Abort reacts to the enable value being written this cycle, so the
  // pins are released in the very next cycle.
  assign abort     = busy && !enable_d;

  assign unused_bits = ^{spi_data_i[31:16], spi_r_addr_i[1:0], spi_w_addr_i[1:0]};

`ifdef SPI_TX_FIFO_EN
  logic [7:0] fifo_q [4];
  logic [1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [2:0] fcnt_q, fcnt_d;

  assign tx_pending = (fcnt_q != 3'd0);
  assign tx_full    = (fcnt_q == 3'd4);
  assign tx_byte    = fifo_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    fcnt_d = fcnt_q;
    if (abort) begin
      wptr_d = 2'd0;
      rptr_d = 2'd0;
      fcnt_d = 3'd0;
    end else begin
      if (tx_accept) wptr_d = wptr_q + 2'd1;
      if (start)     rptr_d = rptr_q + 2'd1;
      case ({tx_accept, start})
        2'b10:   fcnt_d = fcnt_q + 3'd1;
        2'b01:   fcnt_d = fcnt_q - 3'd1;
        default: fcnt_d = fcnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= 2'd0;
      rptr_q <= 2'd0;
      fcnt_q <= 3'd0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      fcnt_q <= fcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_accept) fifo_q[wptr_q] <= spi_data_i[7:0];
  end
`else
  logic       pend_q, pend_d;
  logic [7:0] hold_q;

  assign tx_pending = pend_q;
  assign tx_full    = busy | pend_q;
  assign tx_byte    = hold_q;

  always_comb begin
    pend_d = pend_q;
    if (abort)          pend_d = 1'b0;
    else if (tx_accept) pend_d = 1'b1;
    else if (start)     pend_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pend_q <= 1'b0;
    else     pend_q <= pend_d;
  end

  always_ff @(posedge clk) begin
    if (tx_accept) hold_q <= spi_data_i[7:0];
  end
`endif

  always_comb begin
    enable_d = enable_q;
    irq_en_d = irq_en_q;
    clkdiv_d = clkdiv_q;
    if (w_ctrl) begin
      enable_d = spi_data_i[0];
      irq_en_d = spi_data_i[1];
      clkdiv_d = spi_data_i[15:8];
    end
  end

  // Transfer FSM: SETUP, 16 SHIFT half-periods, HOLD, each clkdiv+1 cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    tx_sh_d = tx_sh_q;
    rx_sh_d = rx_sh_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          tx_sh_d = tx_byte;
          mosi_d  = tx_byte[7];
          cs_n_d  = 1'b0;
          cnt_d   = clkdiv_q;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == 8'd0) begin
          // First rising edge: the slave has had a full half-period with bit 7.
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[6:0], miso};
          half_d  = 4'd0;
          cnt_d   = clkdiv_q;
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_SHIFT: begin
        if (cnt_q == 8'd0) begin
          cnt_d = clkdiv_q;
          if (half_q == 4'd15) begin
            sclk_d  = 1'b0;
            state_d = S_HOLD;
          end else begin
            half_d = half_q + 4'd1;
            if (sclk_q) begin
              sclk_d  = 1'b0;
              tx_sh_d = {tx_sh_q[6:0], 1'b0};
              mosi_d  = tx_sh_q[6];
            end else begin
              sclk_d  = 1'b1;
              rx_sh_d = {rx_sh_q[6:0], miso};
            end
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_HOLD: begin
        if (cnt_q == 8'd0) begin
          cs_n_d  = 1'b1;
          done    = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d = S_IDLE;
      cs_n_d  = 1'b1;
      sclk_d  = 1'b0;
      done    = 1'b0;
    end
  end

  // Completion wins over a same-cycle RXDATA read: the new byte stays valid,
  // and overrun only flags a byte that was never going to be read.
  always_comb begin
    rx_valid_d = rx_valid_q;
    overrun_d  = overrun_q;
    rxdata_d   = rxdata_q;
    if (done) begin
      rxdata_d   = rx_sh_q;
      rx_valid_d = 1'b1;
    end else if (r_rx) begin
      rx_valid_d = 1'b0;
    end
    if (done && rx_valid_q && !r_rx)        overrun_d = 1'b1;
    else if (w_status && spi_data_i[3])     overrun_d = 1'b0;
  end

  // Read mux uses current register values, so a same-cycle write is not visible.
  always_comb begin
    rdata = 32'd0;
    case (spi_r_addr_i[3:2])
      REG_CTRL:   rdata = {16'd0, clkdiv_q, 6'd0, irq_en_q, enable_q};
      REG_STATUS: rdata = {28'd0, overrun_q, rx_valid_q, tx_full, busy};
      REG_RXDATA: rdata = {24'd0, rxdata_q};
      default:    rdata = 32'd0;
    endcase
    data_o_d = r_hit ? rdata : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      half_q     <= 4'd0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      enable_q   <= 1'b0;
      irq_en_q   <= 1'b0;
      clkdiv_q   <= DIV_RESET;
      rx_valid_q <= 1'b0;
      overrun_q  <= 1'b0;
      rxdata_q   <= 8'd0;
      data_o_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      half_q     <= half_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      enable_q   <= enable_d;
      irq_en_q   <= irq_en_d;
      clkdiv_q   <= clkdiv_d;
      rx_valid_q <= rx_valid_d;
      overrun_q  <= overrun_d;
      rxdata_q   <= rxdata_d;
      data_o_q   <= data_o_d;
    end
  end

  always_ff @(posedge clk) begin
    tx_sh_q <= tx_sh_d;
    rx_sh_q <= rx_sh_d;
  end

  assign spi_data_o = data_o_q;
  assign spi_irq_o  = rx_valid_q & irq_en_q;
  assign sclk       = sclk_q;
  assign mosi       = mosi_q;
  assign cs_n       = cs_n_q;

endmodule

// File: doc/spi_master.md
# spi_master

Memory-mapped SPI master peripheral and bus responder on the SoC data bus, alongside the timer and UART. The core initiates reads and writes, and this block decodes them, runs byte-wide SPI mode-0 transfers on external pins, and returns registered read data one cycle later. The SoC read mux uses the previous-cycle read address to select this block's read data.

## Interface
- `SPI_BASE`, default 32'h8000_0200: base byte address; the block decodes 16 bytes.
- `DIV_RESET`, default 8'd4: reset value of the CTRL.clkdiv field.
- `clk` input 1: system clock.
- `rst` input 1: reset, synchronous, active-high.
- `spi_r_addr_i` input 32: bus read address.
- `spi_w_addr_i` input 32: bus write address.
- `spi_data_i` input 32: bus write data.
- `spi_r_enable_i` input 1: read strobe.
- `spi_w_enable_i` input 1: write strobe.
- `spi_data_o` output 32: read data, registered.
- `spi_irq_o` output 1: level interrupt, equal to `rx_valid & CTRL.irq_en`.
- `sclk` output 1: SPI clock, idle low.
- `mosi` output 1: SPI data out, MSB first.
- `miso` input 1: SPI data in.
- `cs_n` output 1: chip select, active low.

## Operation
- Decode: the block is hit when `addr[31:4] == SPI_BASE[31:4]`; `addr[3:2]` selects the register. Accesses that miss the block are ignored, and `spi_data_o` returns 0.
- Registers:
  - 0x0 CTRL (RW): [0] enable; [1] irq_en; [15:8] clkdiv. Reset value is `{DIV_RESET, 8'h00}`.
  - 0x4 STATUS: [0] busy (RO); [1] tx_full (RO); [2] rx_valid (RO); [3] overrun (sticky, cleared by writing 1 to bit 3).
  - 0x8 TXDATA (WO): bits [7:0] queue one byte. The write is dropped if `enable` is 0 or `tx_full` is 1. Reading TXDATA returns 0.
  - 0xC RXDATA (RO): [7:0] last received byte. A read clears `rx_valid`.
- State machine:
  - IDLE: if a byte is pending and `enable` is 1, load the shifter, drive `mosi` with bit 7, assert `cs_n` low, and go to SETUP.
  - SETUP: wait one half-period with `sclk` low, then go to SHIFT.
  - SHIFT: 16 half-periods. On each rising `sclk` edge, sample `miso` into the LSB. On each falling edge, shift and drive the next bit onto `mosi`. After the 16th half-period, go to HOLD.
  - HOLD: wait one half-period with `cs_n` low and `sclk` low. Then deassert `cs_n`, latch the received byte into RXDATA, set `rx_valid`, and return to IDLE.
- A half-period is `clkdiv+1` clk cycles, counted by an 8-bit down-counter. `clkdiv=0` is legal and gives SCLK = clk/2.
- `busy` is 1 in every state except IDLE.
- Clearing `enable` mid-transfer aborts it on the next cycle: the FSM goes to IDLE, `cs_n` goes to 1, `sclk` goes to 0, RXDATA is not updated, and pending bytes are discarded.
- Overrun: if a transfer completes while `rx_valid` is 1, RXDATA is overwritten and `overrun` is set.
- A transfer completion and an RXDATA read in the same cycle: the read returns the old byte, the new byte is latched, and `rx_valid` stays 1. `overrun` is not set in this case.
- A write to a register and a read of the same register in the same cycle: the read returns the pre-write value.

## Timing
- Reset values: `spi_data_o` 0, `spi_irq_o` 0, `sclk` 0, `mosi` 0, `cs_n` 1; FSM in IDLE; all status bits 0.
- Read latency is 1: for a read strobe in cycle N, `spi_data_o` is valid in cycle N+1. Read side effects take effect at the cycle-N edge.
- Writes take effect at the edge of the strobe cycle.
- A TXDATA write in cycle N gives `cs_n` low in cycle N+2 (one cycle for the queue, one for IDLE).
- Total frame length with `cs_n` low is 18×(clkdiv+1) cycles.
- There is at least one idle cycle with `cs_n` high between consecutive frames.

## Configuration
- `SPI_TX_FIFO_EN` defined:
  - TXDATA feeds a 4-entry FIFO (2-bit pointers plus count).
  - `tx_full` means count == 4.
  - Writes are accepted while busy.
  - The FSM pops one entry per frame.
- `SPI_TX_FIFO_EN` undefined:
  - A single holding register is used.
  - `tx_full` equals `busy | pending`.
  - A TXDATA write while a byte is pending or in transfer is dropped.

## Test plan
- Reset: hold `rst` high 3 cycles, then read CTRL, STATUS and RXDATA -> 0x0400, 0, 0; `cs_n=1`, `sclk=0`.
- Loopback with `miso` tied to `mosi`, clkdiv=0, write TXDATA=0xA5 -> `cs_n` low for 18 cycles, 8 `sclk` rising edges, RXDATA=0xA5, `rx_valid=1`; with irq_en=1, `spi_irq_o=1`, and reading RXDATA drops it to 0.
- `miso` driven with 0x3C while sending 0xFF, clkdiv=3 -> frame lasts 72 cycles, RXDATA=0x3C.
- Two transfers completed without reading RXDATA -> RXDATA holds the second byte, `overrun=1`; writing STATUS=0x8 clears it.
- Write 5 bytes back-to-back while busy:
  - with `SPI_TX_FIFO_EN` -> 4 frames sent; the 5th write is dropped because `tx_full` is 1.
  - without it -> 1 frame sent.
- Clear `enable` mid-frame at bit 3 -> next cycle `cs_n=1`, busy=0, RXDATA unchanged, `rx_valid` unchanged.
